// File: rtl/cla_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cla_pkg
//  Purpose  : Shared constants, mode encodings and group lookahead helper for
//             the pipelined carry-lookahead adder.
//  Revision : 1.0  initial release
// ============================================================================
package cla_pkg;

    localparam int GROUP = 4;

    typedef enum logic {
        ADD = 1'b0,
        SUB = 1'b1
    } mode_e;

    function automatic int NGROUPS(input int width);
        return width / GROUP;
    endfunction

    // Returns {group generate, group propagate} for one 4-bit group.
    function automatic logic [1:0] group_gen_prop(input logic [GROUP-1:0] g,
                                                  input logic [GROUP-1:0] p);
        logic gg;
        gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        return {gg, &p};
    endfunction

endpackage
`default_nettype wire

// File: rtl/cla_group.sv
`default_nettype none
// ============================================================================
//  Module   : cla_group
//  Purpose  : 4-bit lookahead group: group G/P and the carry into each bit
//             from the group carry-in.
//  Revision : 1.0  initial release
// ============================================================================
module cla_group
    import cla_pkg::*;
(
    input  logic [GROUP-1:0] i_g,
    input  logic [GROUP-1:0] i_p,
    input  logic             i_cin,
    output logic             o_gg,
    output logic             o_gp,
    output logic [GROUP-1:0] o_c
);

    assign {o_gg, o_gp} = group_gen_prop(i_g, i_p);

    // Fully expanded lookahead so no carry ripples inside the group.
    assign o_c[0] = i_cin;
    assign o_c[1] = i_g[0] | (i_p[0] & i_cin);
    assign o_c[2] = i_g[1] | (i_p[1] & i_g[0]) | (i_p[1] & i_p[0] & i_cin);
    assign o_c[3] = i_g[2] | (i_p[2] & i_g[1]) | (i_p[2] & i_p[1] & i_g[0])
                  | (i_p[2] & i_p[1] & i_p[0] & i_cin);

endmodule
`default_nettype wire

// File: rtl/pipelined_cla_adder.sv
`default_nettype none
// ============================================================================
//  Module   : pipelined_cla_adder
//  Purpose  : Two-stage carry-lookahead add/subtract with valid/ready flow
//             control on both sides.
//  Revision : 1.0  initial release
// ============================================================================
module pipelined_cla_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int c_ngroups = NGROUPS(WIDTH);

    logic [WIDTH-1:0]     w_b_eff, w_p, w_g;
    logic                 w_cin_eff;
    logic [c_ngroups-1:0] w_gg, w_gp;
    logic                 w_s2_free, w_s1_adv, w_in_xfer;

    logic                 r_s1_valid, r_s1_cin, r_s1_a_msb, r_s1_b_msb;
    logic [WIDTH-1:0]     r_s1_p, r_s1_g;
    logic [c_ngroups-1:0] r_s1_gg, r_s1_gp;

    logic [c_ngroups:0]   w_gc;
    logic [WIDTH-1:0]     w_c, w_sum;
    logic                 w_cout, w_ovf;
    logic [c_ngroups-1:0] w_unused_gg, w_unused_gp;
    logic                 w_unused;

    logic                 r_s2_valid, r_cout, r_ovf, r_zero;
    logic [WIDTH-1:0]     r_sum;

    // Subtraction is A + ~B + 1; cin only matters when adding.
    assign w_b_eff   = (mode_e'(sub) == SUB) ? ~b : b;
    assign w_cin_eff = (mode_e'(sub) == SUB) ? 1'b1 : cin;
    assign w_p       = a ^ w_b_eff;
    assign w_g       = a & w_b_eff;

    generate
        for (genvar k = 0; k < c_ngroups; k++) begin : g_s1_group
            assign {w_gg[k], w_gp[k]} = group_gen_prop(w_g[k*GROUP +: GROUP],
                                                       w_p[k*GROUP +: GROUP]);
        end
    endgenerate

    assign w_s2_free = !r_s2_valid || out_ready;
    assign w_s1_adv  = r_s1_valid && w_s2_free;
    assign in_ready  = !r_s1_valid || w_s1_adv;
    assign w_in_xfer = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (w_in_xfer) begin
            r_s1_p     <= w_p;
            r_s1_g     <= w_g;
            r_s1_gg    <= w_gg;
            r_s1_gp    <= w_gp;
            r_s1_cin   <= w_cin_eff;
            r_s1_a_msb <= a[WIDTH-1];
            r_s1_b_msb <= w_b_eff[WIDTH-1];
        end
    end

    // Group-level lookahead chain: C[k+1] = GG[k] | GP[k] & C[k].
    always_comb begin
        logic c;
        c       = r_s1_cin;
        w_gc    = '0;
        w_gc[0] = c;
        for (int k = 0; k < c_ngroups; k++) begin
            c         = r_s1_gg[k] | (r_s1_gp[k] & c);
            w_gc[k+1] = c;
        end
    end

    generate
        for (genvar k = 0; k < c_ngroups; k++) begin : g_s2_group
            cla_group u_group (
                .i_g   (r_s1_g[k*GROUP +: GROUP]),
                .i_p   (r_s1_p[k*GROUP +: GROUP]),
                .i_cin (w_gc[k]),
                .o_gg  (w_unused_gg[k]),
                .o_gp  (w_unused_gp[k]),
                .o_c   (w_c[k*GROUP +: GROUP])
            );
        end
    endgenerate

    assign w_sum  = r_s1_p ^ w_c;
    assign w_cout = w_gc[c_ngroups];
    assign w_ovf  = w_c[WIDTH-1] ^ w_cout;

    // Group G/P is recomputed per group and operand signs are kept for debug only.
    assign w_unused = ^{w_unused_gg, w_unused_gp, r_s1_a_msb, r_s1_b_msb};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_sum      <= '0;
            r_cout     <= 1'b0;
            r_ovf      <= 1'b0;
            r_zero     <= 1'b0;
        end else if (w_s2_free) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_sum  <= w_sum;
                r_cout <= w_cout;
                r_ovf  <= w_ovf;
                r_zero <= (w_sum == '0);
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign zero      = r_zero;

endmodule
`default_nettype wire
